hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage core. It generates the 2-bit select inputs of the execute-stage forwarding muxes and the 1-bit selects of the decode-stage branch-compare muxes.
- It also drives stall and flush for the fetch, decode and execute pipeline registers.
- It owns the multi-cycle multiply/divide busy timer and a saturating stall-cycle counter.
- Muxes consume its selects; this block is the producer side of that select interface.

Parameters:
- RW, 5, register-index width.
- MD_LAT, 32, multiply/divide occupancy in cycles (≥1).
- CW, 32, stall-counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- rs_d, rt_d  in  RW  source registers of the decode-stage instruction.
- rs_e, rt_e  in  RW  source registers of the execute-stage instruction.
- writereg_e, writereg_m, writereg_w  in  RW  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  destination-write enable per stage.
- memtoreg_e, memtoreg_m  in  1  stage holds a load.
- branch_d  in  1  decode holds beq/bne.
- md_op_d  in  1  decode holds mult/div/mfhi/mflo/mthi/mtlo.
- md_start_e  in  1  execute issues mult/div this cycle.
- forward_a_e, forward_b_e  out  2  execute-stage mux selects.
- forward_a_d, forward_b_d  out  1  decode-stage compare-mux selects.
- stall_f, stall_d  out  1  hold the PC and the IF/ID register.
- flush_e  out  1  clear the ID/EX register (insert bubble).
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  CW  total stalled cycles, saturating.

Behaviour:

Forwarding (combinational)
- Encoding: 0 = regfile, 1 = writeback result, 2 = memory-stage ALU result. Code 3 is never driven.
- forward_a_e:
  - 2 if rs_e≠0 and regwrite_m and writereg_m==rs_e.
  - Else 1 if rs_e≠0 and regwrite_w and writereg_w==rs_e.
  - Else 0.
- forward_b_e: same rule using rt_e.
- The memory stage has priority over writeback when both match.
- forward_a_d = rs_d≠0 and regwrite_m and writereg_m==rs_d. forward_b_d uses rt_d in the same way.
- Register 0 is never forwarded.

Stall conditions (combinational)
- lwstall = memtoreg_e and writereg_e≠0 and (writereg_e==rs_d or writereg_e==rt_d).
- brstall = branch_d and either:
  - regwrite_e and writereg_e≠0 and writereg_e matches rs_d or rt_d; or
  - memtoreg_m and writereg_m≠0 and writereg_m matches rs_d or rt_d.
- mdstall = md_op_d and (md_busy or md_start_e).
- stall_d = stall_f = flush_e = lwstall | brstall | mdstall.

Multiply/divide timer (sub-module, sequential)
- count register, width $clog2(MD_LAT+1). md_busy = (count≠0).
- Clock edge with md_start_e and count==0: count loads MD_LAT.
- Otherwise, if count≠0: count decrements by 1.
- md_start_e while count≠0 is ignored and the count continues. This cannot occur legally, because mdstall blocks it; the bench flags it with an assertion.
- Result: md_busy is high for exactly MD_LAT cycles, starting the cycle after the start edge.

Stall counter (sequential)
- On each clock edge where stall_d=1: stall_cnt increments by 1, saturating at all-ones. Once saturated it does not wrap.

Reset
- Asynchronous; takes effect immediately, including mid-operation.
- count=0, so md_busy=0. stall_cnt=0.
- Combinational outputs follow their inputs while reset is high, except mdstall, which uses md_busy=0.

Decomposition:
- Shared package hazard_pkg holds:
  - Encoding constants FWD_RF=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2.
  - Localparam REG_ZERO=0.
  - The mux-select typedef, shared with the datapath muxes.
- One sub-module, md_timer, contains the count register and md_busy.

Test Plan:
- Forwarding priority: rs_e=5; writereg_m=5, regwrite_m=1; writereg_w=5, regwrite_w=1 -> forward_a_e=2. Drop regwrite_m -> forward_a_e=1.
- Zero register: rs_e=0 with all stage writes targeting 0 -> forward_a_e=0, forward_b_e=0, forward_a_d=0.
- Load-use: memtoreg_e=1, writereg_e=8, rt_d=8 -> stall_f=stall_d=flush_e=1 for one cycle, stall_cnt 0→1. Next cycle, with the load in M and branch_d=0 -> no stall.
- Branch hazard: branch_d=1, rs_d=3, regwrite_e=1, writereg_e=3 -> stall asserted. Then memtoreg_m=1 with writereg_m=3 -> stall asserted again. After that -> forward_a_d=1 with no stall.
- Mult/div timing (MD_LAT=4): md_start_e pulse at cycle 0 -> md_busy high during cycles 1–4, low at cycle 5. md_op_d held high -> stall_d high during cycles 0–4. Assert reset at cycle 2 -> md_busy drops immediately and stall_cnt=0.
- Saturation (CW=4): hold lwstall for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_pkg: forwarding-select encoding shared with datapath muxes  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hazard_pkg;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'd0;
   localparam fwd_sel_t FWD_WB  = 2'd1;
   localparam fwd_sel_t FWD_MEM = 2'd2;

   localparam int REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_md_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | md_timer: multiply/divide occupancy down-counter                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module md_timer
   import hazard_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   output logic md_busy
);

   localparam int c_cnt_w = $clog2(MD_LAT + 1);
   localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(MD_LAT);
   localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_count;

   // A start while the unit is still counting is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (r_count == '0) begin
         if (md_start) begin
            r_count <= c_load;
         end
      end else begin
         r_count <= r_count - c_one;
      end
   end

   assign md_busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_unit: forwarding selects, stall/flush and stall counter     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int RW     = 5,
   parameter int MD_LAT = 32,
   parameter int CW     = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] rs_d,
   input  logic [RW-1:0] rt_d,
   input  logic [RW-1:0] rs_e,
   input  logic [RW-1:0] rt_e,
   input  logic [RW-1:0] writereg_e,
   input  logic [RW-1:0] writereg_m,
   input  logic [RW-1:0] writereg_w,
   input  logic          regwrite_e,
   input  logic          regwrite_m,
   input  logic          regwrite_w,
   input  logic          memtoreg_e,
   input  logic          memtoreg_m,
   input  logic          branch_d,
   input  logic          md_op_d,
   input  logic          md_start_e,
   output fwd_sel_t      forward_a_e,
   output fwd_sel_t      forward_b_e,
   output logic          forward_a_d,
   output logic          forward_b_d,
   output logic          stall_f,
   output logic          stall_d,
   output logic          flush_e,
   output logic          md_busy,
   output logic [CW-1:0] stall_cnt
);

   localparam logic [RW-1:0] c_zero = RW'(REG_ZERO);
   localparam logic [CW-1:0] c_one  = CW'(1);

   logic          w_lwstall;
   logic          w_brstall;
   logic          w_mdstall;
   logic          w_stall;
   logic          w_d_hit_e;
   logic          w_d_hit_m;
   logic [CW-1:0] r_stall_cnt;

   // Memory stage wins over writeback: it holds the younger result.
   always_comb begin
      forward_a_e = FWD_RF;
      if (rs_e != c_zero && regwrite_m && writereg_m == rs_e) begin
         forward_a_e = FWD_MEM;
      end else if (rs_e != c_zero && regwrite_w && writereg_w == rs_e) begin
         forward_a_e = FWD_WB;
      end

      forward_b_e = FWD_RF;
      if (rt_e != c_zero && regwrite_m && writereg_m == rt_e) begin
         forward_b_e = FWD_MEM;
      end else if (rt_e != c_zero && regwrite_w && writereg_w == rt_e) begin
         forward_b_e = FWD_WB;
      end
   end

   assign forward_a_d = (rs_d != c_zero) && regwrite_m && (writereg_m == rs_d);
   assign forward_b_d = (rt_d != c_zero) && regwrite_m && (writereg_m == rt_d);

   assign w_d_hit_e = (writereg_e != c_zero) && (writereg_e == rs_d || writereg_e == rt_d);
   assign w_d_hit_m = (writereg_m != c_zero) && (writereg_m == rs_d || writereg_m == rt_d);

   assign w_lwstall = memtoreg_e && w_d_hit_e;
   assign w_brstall = branch_d && ((regwrite_e && w_d_hit_e) || (memtoreg_m && w_d_hit_m));
   assign w_mdstall = md_op_d && (md_busy || md_start_e);
   assign w_stall   = w_lwstall || w_brstall || w_mdstall;

   assign stall_f = w_stall;
   assign stall_d = w_stall;
   assign flush_e = w_stall;

   md_timer #(
      .MD_LAT (MD_LAT)
   ) u_md_timer (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start_e),
      .md_busy  (md_busy)
   );

   // Saturates at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && r_stall_cnt != '1) begin
         r_stall_cnt <= r_stall_cnt + c_one;
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
